// File: rtl/uart_cmd_pkg.sv
// ============================================================================
// Module   : uart_cmd_pkg
// Purpose  : Shared constants, state enums and the byte-encoding helper for
//            the APU register-write command protocol carried over UART.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_cmd_pkg;

  // Upper nibble that marks a bank-select byte on the wire.
  localparam logic [3:0] CMD_BANK    = 4'h8;

  // Bit 4 of a data byte says which half of the register value it carries.
  // The receiver commits the write when it sees the high half.
  localparam logic       LOW_NIBBLE  = 1'b0;
  localparam logic       HIGH_NIBBLE = 1'b1;

  // Command sequencer: which byte of the current request is on the wire.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BANK = 2'd1,
    LOW  = 2'd2,
    HIGH = 2'd3
  } cmd_state_e;

  // Byte serializer phases.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } ser_state_e;

  // Data byte layout: {0, addr[1:0], hi/lo flag, nibble[3:0]}.
  function automatic logic [7:0] encode_byte(input logic [1:0] addr,
                                             input logic       hi,
                                             input logic [3:0] nibble);
    return {1'b0, addr, hi, nibble};
  endfunction

  // Bank-select byte layout: {CMD_BANK, bank[3:0]}.
  function automatic logic [7:0] bank_byte(input logic [3:0] bank);
    return {CMD_BANK, bank};
  endfunction

endpackage : uart_cmd_pkg

`default_nettype wire

// File: rtl/uart_reg_writer_if.sv
// ============================================================================
// Module   : uart_reg_writer_if
// Purpose  : Valid/ready register-write request channel (bank, addr, data).
//            The master offers a request; the slave (uart_reg_writer)
//            accepts it on a clock edge where wr_valid && wr_ready.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_reg_writer_if;

  logic       wr_valid;
  logic       wr_ready;
  logic [3:0] wr_bank;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;

  modport master (
    output wr_valid,
    output wr_bank,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_bank,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );

endinterface : uart_reg_writer_if

`default_nettype wire

// File: rtl/uart_tx_byte.sv
// ============================================================================
// Module   : uart_tx_byte
// Purpose  : 8N1 UART byte serializer. A load pulse starts a frame (start bit,
//            8 data bits LSB first, stop bit). done pulses in the last cycle
//            of the final stop bit so a new load in that same cycle sends the
//            next frame back to back. tx comes straight from a flop.
// Options  : `define UART_STOP2_EN for two stop bits per frame.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_byte
  import uart_cmd_pkg::*;
#(
  parameter int unsigned BIT_DIV = 1250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] byte_in,
  output logic       done,
  output logic       tx
);

  localparam int unsigned      CNT_W    = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_DIV - 1);

  // Index of the final stop bit. The stop phase reuses the data-bit counter
  // to count stop bits.
`ifdef UART_STOP2_EN
  localparam logic [2:0] STOP_LAST = 3'd1;
`else
  localparam logic [2:0] STOP_LAST = 3'd0;
`endif

  // A bit period shorter than two clocks cannot be timed by this counter.
  generate
    if (BIT_DIV < 2) begin : g_bit_div_check
      $error("uart_tx_byte: BIT_DIV must be >= 2");
    end
  endgenerate

  ser_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [2:0]       bit_q,   bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q,    tx_d;
  logic             bit_end;

  assign bit_end = (cnt_q == CNT_LAST);
  assign tx      = tx_q;

  // Next-state logic: advance one bit at each bit boundary; load wins.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    done    = 1'b0;

    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        // shift_q[0] always holds the bit currently on the line.
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            bit_d   = 3'd0;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            done    = 1'b1;
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // A new byte starts its start bit on the very next cycle.
    if (load) begin
      state_d = S_START;
      cnt_d   = '0;
      bit_d   = 3'd0;
      shift_d = byte_in;
      tx_d    = 1'b0;
    end
  end

  // Serializer registers; reset forces the line back to idle-high at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule : uart_tx_byte

`default_nettype wire

// File: rtl/uart_reg_writer.sv
// ============================================================================
// Module   : uart_reg_writer
// Purpose  : Host-side register-write command transmitter. Accepts
//            (bank, addr, data) requests on a valid/ready channel, encodes
//            each as [bank byte] + low-nibble byte + high-nibble byte and
//            sends them back to back over 8N1 UART. The bank byte is skipped
//            when the receiver is already known to be on the requested bank.
// Options  : `define UART_STOP2_EN for two stop bits per frame (handled in
//            uart_tx_byte; encoding and handshake are unchanged).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_reg_writer
  import uart_cmd_pkg::*;
#(
  parameter int unsigned CLK_HZ = 12000000,
  parameter int unsigned BAUD   = 9600
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_reg_writer_if.slave   wr,
  output logic               tx,
  output logic               busy
);

  localparam int unsigned BIT_DIV = CLK_HZ / BAUD;

  cmd_state_e state_q,      state_d;
  logic       bank_known_q, bank_known_d;
  logic [3:0] bank_reg_q,   bank_reg_d;
  logic [1:0] addr_q,       addr_d;
  logic [7:0] data_q,       data_d;

  logic       accept;
  logic       need_bank;
  logic       load;
  logic [7:0] byte_in;
  logic       done;

  assign wr.wr_ready = (state_q == IDLE);
  assign accept      = wr.wr_valid && wr.wr_ready;
  assign busy        = (state_q != IDLE);

  // The receiver's bank is only trusted once we have sent it ourselves.
  assign need_bank   = !bank_known_q || (wr.wr_bank != bank_reg_q);

  // Command sequencing: pick the next byte and hand it over as soon as the
  // previous frame's last stop bit ends.
  always_comb begin
    state_d      = state_q;
    bank_known_d = bank_known_q;
    bank_reg_d   = bank_reg_q;
    addr_d       = addr_q;
    data_d       = data_q;
    load         = 1'b0;
    byte_in      = 8'h00;

    case (state_q)
      IDLE: begin
        if (accept) begin
          load   = 1'b1;
          addr_d = wr.wr_addr;
          data_d = wr.wr_data;
          if (need_bank) begin
            state_d      = BANK;
            byte_in      = bank_byte(wr.wr_bank);
            bank_reg_d   = wr.wr_bank;
            bank_known_d = 1'b1;
          end else begin
            state_d = LOW;
            byte_in = encode_byte(wr.wr_addr, LOW_NIBBLE, wr.wr_data[3:0]);
          end
        end
      end
      BANK: begin
        if (done) begin
          state_d = LOW;
          load    = 1'b1;
          byte_in = encode_byte(addr_q, LOW_NIBBLE, data_q[3:0]);
        end
      end
      LOW: begin
        if (done) begin
          state_d = HIGH;
          load    = 1'b1;
          byte_in = encode_byte(addr_q, HIGH_NIBBLE, data_q[7:4]);
        end
      end
      HIGH: begin
        if (done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Command state and captured request fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bank_known_q <= 1'b0;
      bank_reg_q   <= 4'h0;
      addr_q       <= 2'd0;
      data_q       <= 8'h00;
    end else begin
      state_q      <= state_d;
      bank_known_q <= bank_known_d;
      bank_reg_q   <= bank_reg_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
    end
  end

  uart_tx_byte #(
    .BIT_DIV (BIT_DIV)
  ) u_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .byte_in (byte_in),
    .done    (done),
    .tx      (tx)
  );

endmodule : uart_reg_writer

`default_nettype wire

// File: tb/tb_uart_reg_writer.sv
// ============================================================================
// Module   : tb_uart_reg_writer
// Purpose  : Self-checking bench for uart_reg_writer. A line-level model
//            predicts tx/busy/wr_ready every cycle from the protocol rules;
//            a simple UART receiver recovers the bytes for literal checks.
//            The clock/baud pair is scaled down (10 clocks per bit) to keep
//            run time short; the frame structure is identical.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_reg_writer;

  localparam int TB_CLK_HZ = 96000;
  localparam int TB_BAUD   = 9600;
  localparam int BIT_DIV   = TB_CLK_HZ / TB_BAUD;
`ifdef UART_STOP2_EN
  localparam int STOP_BITS = 2;
`else
  localparam int STOP_BITS = 1;
`endif
  localparam int FRAME_CYC = (9 + STOP_BITS) * BIT_DIV;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx;
  logic busy;

  uart_reg_writer_if wif();

  uart_reg_writer #(
    .CLK_HZ (TB_CLK_HZ),
    .BAUD   (TB_BAUD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wr    (wif.slave),
    .tx    (tx),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- line-level model ----------------
  // mq holds the expected tx level for every remaining busy cycle.
  bit         mq[$];
  bit         m_known;
  logic [3:0] m_bank;
  int         acc_cnt = 0;

  function automatic void push_frame(input int value);
    for (int i = 0; i < BIT_DIV; i++) mq.push_back(1'b0);
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < BIT_DIV; i++) mq.push_back(((value >> k) & 1) != 0);
    for (int i = 0; i < STOP_BITS * BIT_DIV; i++) mq.push_back(1'b1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_known <= 1'b0;
      m_bank  <= 4'h0;
    end else if (mq.size() != 0) begin
      void'(mq.pop_front());
    end else if (wif.wr_valid === 1'b1) begin
      if (!m_known || m_bank != wif.wr_bank) begin
        push_frame(128 + int'(wif.wr_bank));
        m_known <= 1'b1;
        m_bank  <= wif.wr_bank;
      end
      push_frame(int'(wif.wr_addr) * 32 + int'(wif.wr_data) % 16);
      push_frame(int'(wif.wr_addr) * 32 + 16 + int'(wif.wr_data) / 16);
      acc_cnt <= acc_cnt + 1;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      check("tx",       tx,           (mq.size() != 0) ? mq[0] : 1'b1);
      check("busy",     busy,         mq.size() != 0);
      check("wr_ready", wif.wr_ready, mq.size() == 0);
    end
  end

  // Busy pulse length measurement.
  int busy_run = 0;
  int last_busy_run = 0;
  always @(negedge clk) begin
    if (busy === 1'b1) begin
      busy_run <= busy_run + 1;
    end else if (busy_run != 0) begin
      last_busy_run <= busy_run;
      busy_run      <= 0;
    end
  end

  // ---------------- simple UART receiver ----------------
  logic [7:0] rxq[$];
  initial begin : rx_proc
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (rst_n && tx === 1'b0) begin
        repeat (BIT_DIV / 2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          repeat (BIT_DIV) @(negedge clk);
          b[k] = tx;
        end
        repeat (BIT_DIV) @(negedge clk);
        rxq.push_back(b);
      end
    end
  end

  task automatic expect_rx(input string name, input int n,
                           input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] e[4];
    e = '{e0, e1, e2, e3};
    check({name, "_count"}, rxq.size(), n);
    for (int i = 0; i < n; i++)
      check(name, (rxq.size() > i) ? rxq[i] : 8'hxx, e[i]);
    rxq.delete();
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic issue(input logic [3:0] b, input logic [1:0] a, input logic [7:0] d);
    int start;
    int t;
    start = acc_cnt;
    t = 0;
    @(negedge clk);
    wif.wr_valid = 1'b1;
    wif.wr_bank  = b;
    wif.wr_addr  = a;
    wif.wr_data  = d;
    while (acc_cnt == start && t < 20 * FRAME_CYC) begin
      @(negedge clk);
      t++;
    end
    check("accept", acc_cnt - start, 1);
  endtask

  task automatic release_req();
    @(negedge clk);
    wif.wr_valid = 1'b0;
    wif.wr_bank  = 4'($urandom);
    wif.wr_addr  = 2'($urandom);
    wif.wr_data  = 8'($urandom);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (mq.size() != 0 && t < 10 * FRAME_CYC) begin
      @(negedge clk);
      t++;
    end
    check("idle", mq.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    wif.wr_valid = 1'b0;
    wif.wr_bank  = 4'h0;
    wif.wr_addr  = 2'd0;
    wif.wr_data  = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx",    tx,           1);
    check("rst_busy",  busy,         0);
    check("rst_ready", wif.wr_ready, 1);
    rst_n = 1'b1;

    repeat (2000) @(negedge clk);
    check("idle_tx",    tx,           1);
    check("idle_busy",  busy,         0);
    check("idle_ready", wif.wr_ready, 1);

    // First request: bank byte is always sent after reset.
    issue(4'h0, 2'd1, 8'hA7);
    check("model_len", mq.size(), 3 * FRAME_CYC);
    release_req();
    wait_idle();
    expect_rx("req1", 3, 8'h80, 8'h27, 8'h3A, 8'h00);
    check("busy_len", last_busy_run, 3 * FRAME_CYC);

    // Same bank: no bank byte.
    issue(4'h0, 2'd0, 8'h82);
    release_req();
    wait_idle();
    expect_rx("req2", 2, 8'h02, 8'h18, 8'h00, 8'h00);
    check("busy_len2", last_busy_run, 2 * FRAME_CYC);

    // Valid held high across two requests.
    issue(4'h0, 2'd2, 8'h7C);
    issue(4'h0, 2'd3, 8'h09);
    release_req();
    wait_idle();
    expect_rx("req34", 4, 8'h4C, 8'h57, 8'h69, 8'h70);

    // Bank change, then same new bank.
    issue(4'h1, 2'd3, 8'h0A);
    release_req();
    wait_idle();
    expect_rx("req5", 3, 8'h81, 8'h6A, 8'h70, 8'h00);
    issue(4'h1, 2'd0, 8'h5F);
    release_req();
    wait_idle();
    expect_rx("req6", 2, 8'h0F, 8'h15, 8'h00, 8'h00);

    // Reset during data bit 4 of the second byte (0x4C, bit 4 = 0).
    issue(4'h0, 2'd2, 8'h3C);
    release_req();
    repeat (FRAME_CYC + 5 * BIT_DIV + 3) @(negedge clk);
    check("pre_rst_tx", tx, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_tx",    tx,           1);
    check("async_rst_busy",  busy,         0);
    check("async_rst_ready", wif.wr_ready, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * FRAME_CYC) @(negedge clk);
    rxq.delete();

    // Bank 0 again: bank byte must be re-sent after reset.
    issue(4'h0, 2'd1, 8'h93);
    release_req();
    wait_idle();
    expect_rx("req8", 3, 8'h80, 8'h23, 8'h39, 8'h00);

    check("end_tx",   tx,   1);
    check("end_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_uart_reg_writer

`default_nettype wire
